// File: rtl/sprite_blitter.sv
// Sprite blitter: copies an SPR_W x SPR_H sprite from a shared synchronous ROM to the frame buffer.
// Optional colour-key transparency is enabled by defining SPRITE_TRANSPARENCY_EN.
module sprite_blitter #(
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int COLOUR_W    = 9,
    parameter int SPR_W       = 16,
    parameter int SPR_H       = 16,
    parameter int NUM_SPRITES = 2,
    parameter int ROM_LAT     = 1,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = 9'h1FF,
`ifdef SPRITE_TRANSPARENCY_EN
    parameter logic [COLOUR_W-1:0] TRANSPARENT_KEY = 9'h000,
`endif
    localparam int SEL_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int ADDR_W = $clog2(NUM_SPRITES * SPR_W * SPR_H)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [SEL_W-1:0]    sprite_sel,
    input  logic                erase,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic                busy,
    output logic                done,
    output logic                plot,
    output logic [X_W-1:0]      xout,
    output logic [Y_W-1:0]      yout,
    output logic [COLOUR_W-1:0] colour
);

    localparam int N     = SPR_W * SPR_H;
    localparam int K_W   = $clog2(N);
    localparam int COL_W = $clog2(SPR_W);
    localparam int DC_W  = $clog2(ROM_LAT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state;
    logic [K_W-1:0]    k;
    logic [DC_W-1:0]   drain_cnt;
    logic [X_W-1:0]    x0_l;
    logic [Y_W-1:0]    y0_l;
    logic [SEL_W-1:0]  sel_l;
    logic              erase_l;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            k         <= '0;
            drain_cnt <= '0;
            x0_l      <= '0;
            y0_l      <= '0;
            sel_l     <= '0;
            erase_l   <= 1'b0;
            rom_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        k        <= '0;
                        x0_l     <= x0;
                        y0_l     <= y0;
                        sel_l    <= sprite_sel;
                        erase_l  <= erase;
                        rom_addr <= ADDR_W'({sprite_sel, {K_W{1'b0}}});
                    end
                end
                FETCH: begin
                    if (k == K_W'(N - 1)) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        k        <= k + 1'b1;
                        rom_addr <= ADDR_W'({sel_l, k + 1'b1});
                    end
                end
                DRAIN: begin
                    // Wait for the ROM pipeline to deliver the last pixel
                    if (drain_cnt == DC_W'(ROM_LAT - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pixel index travels alongside the ROM read so coordinates line up with rom_data
    logic           v_sr [ROM_LAT];
    logic [K_W-1:0] k_sr [ROM_LAT];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < ROM_LAT; i++) begin
                v_sr[i] <= 1'b0;
                k_sr[i] <= '0;
            end
        end else begin
            v_sr[0] <= (state == FETCH);
            k_sr[0] <= k;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                v_sr[i] <= v_sr[i-1];
                k_sr[i] <= k_sr[i-1];
            end
        end
    end

    logic                slot_v;
    logic [K_W-1:0]      slot_k;
    logic [X_W-1:0]      pix_x;
    logic [Y_W-1:0]      pix_y;
    logic [COLOUR_W-1:0] pix_c;
    logic                key_hit;
    logic [X_W-1:0]      x_hold;
    logic [Y_W-1:0]      y_hold;
    logic [COLOUR_W-1:0] c_hold;

    always_comb begin
        slot_v = v_sr[ROM_LAT-1];
        slot_k = k_sr[ROM_LAT-1];
        pix_x  = x0_l + X_W'(slot_k[COL_W-1:0]);
        pix_y  = y0_l + Y_W'(slot_k[K_W-1:COL_W]);
        pix_c  = erase_l ? BG_COLOUR : rom_data;
`ifdef SPRITE_TRANSPARENCY_EN
        key_hit = !erase_l && (rom_data == TRANSPARENT_KEY);
`else
        key_hit = 1'b0;
`endif
    end

    // rom_data only becomes valid in the slot cycle, so outputs bypass the hold registers then
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_hold <= '0;
            y_hold <= '0;
            c_hold <= '0;
        end else if (slot_v) begin
            x_hold <= pix_x;
            y_hold <= pix_y;
            c_hold <= pix_c;
        end
    end

    always_comb begin
        plot   = slot_v && !key_hit;
        xout   = slot_v ? pix_x : x_hold;
        yout   = slot_v ? pix_y : y_hold;
        colour = slot_v ? pix_c : c_hold;
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: randomized draws scored against a pixel-list model.
module tb_sprite_blitter;

    localparam int N     = 256;
    localparam int LAT   = 1;
    localparam int SPR_W = 16;
    localparam int MAXC  = 600;
`ifdef SPRITE_TRANSPARENCY_EN
    localparam logic [8:0] KEY = 9'h000;
`endif

    logic       clk = 1'b0;
    logic       resetn, start, sprite_sel, erase;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [8:0] rom_addr, rom_data;
    logic       busy, done, plot;
    logic [7:0] xout;
    logic [6:0] yout;
    logic [8:0] colour;

    always #5 clk = ~clk;

    logic [8:0] rom_mem [512];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    sprite_blitter #(.ROM_LAT(LAT)) dut (
        .clk(clk), .resetn(resetn), .start(start), .x0(x0), .y0(y0),
        .sprite_sel(sprite_sel), .erase(erase), .rom_addr(rom_addr),
        .rom_data(rom_data), .busy(busy), .done(done), .plot(plot),
        .xout(xout), .yout(yout), .colour(colour)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // per-cycle tuple {busy, done, plot, x[7:0], y[6:0], colour[8:0]}
    logic [26:0] obs_vec [MAXC];
    logic [26:0] exp_vec [MAXC];
    logic [8:0]  obs_addr [MAXC];
    logic [8:0]  e_addr [MAXC];
    bit          e_addr_en [MAXC];
    bit          e_slot [MAXC], e_plot [MAXC], e_busy [MAXC], e_done [MAXC];
    logic [7:0]  e_px [MAXC];
    logic [6:0]  e_py [MAXC];
    logic [8:0]  e_pc [MAXC];
    logic [7:0]  m_x;
    logic [6:0]  m_y;
    logic [8:0]  m_c;
    int          rst_cut;

    function automatic bit model_plots(input logic [8:0] c, input bit e);
`ifdef SPRITE_TRANSPARENCY_EN
        return e || (c != KEY);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_clear();
        for (int j = 0; j < MAXC; j++) begin
            e_slot[j] = 0; e_plot[j] = 0; e_busy[j] = 0; e_done[j] = 0;
            e_addr_en[j] = 0; e_addr[j] = '0;
            e_px[j] = '0; e_py[j] = '0; e_pc[j] = '0;
        end
        rst_cut = 0;
    endtask

    // A draw accepted at edge `base` produces pixel k in cycle base+1+k+LAT
    task automatic model_draw(input int base, input int x, input int y, input int s, input bit e);
        for (int k = 0; k < N; k++) begin
            int j;
            logic [8:0] c;
            j = base + 1 + k + LAT;
            c = rom_mem[s*N + k];
            e_slot[j] = 1;
            e_px[j]   = 8'((x + k % SPR_W) % 256);
            e_py[j]   = 7'((y + k / SPR_W) % 128);
            e_pc[j]   = e ? 9'h1FF : c;
            e_plot[j] = model_plots(c, e);
            e_addr_en[base+1+k] = 1;
            e_addr[base+1+k]    = 9'(s*N + k);
        end
        for (int j = base + 1; j <= base + N + LAT; j++) e_busy[j] = 1;
        e_done[base + N + LAT + 1] = 1;
    endtask

    task automatic model_reset(input int at);
        for (int j = at + 1; j < MAXC; j++) begin
            e_slot[j] = 0; e_plot[j] = 0; e_busy[j] = 0; e_done[j] = 0;
            e_addr_en[j] = 1; e_addr[j] = '0;
        end
        rst_cut = at;
    endtask

    task automatic model_finalize(input int n);
        logic [7:0] cx;
        logic [6:0] cy;
        logic [8:0] cc;
        cx = m_x; cy = m_y; cc = m_c;
        for (int j = 1; j <= n; j++) begin
            if (rst_cut > 0 && j == rst_cut + 1) begin
                cx = '0; cy = '0; cc = '0;
            end
            if (e_slot[j]) begin
                cx = e_px[j]; cy = e_py[j]; cc = e_pc[j];
            end
            exp_vec[j] = {e_busy[j], e_done[j], e_plot[j], cx, cy, cc};
        end
        m_x = cx; m_y = cy; m_c = cc;
    endtask

    task automatic fill_rom_random();
        for (int i = 0; i < 512; i++) rom_mem[i] = 9'($urandom);
    endtask

    task automatic kick(input int x, input int y, input int s, input bit e);
        @(negedge clk);
        x0 = 8'(x); y0 = 7'(y); sprite_sel = s[0]; erase = e; start = 1'b1;
        @(posedge clk); #1;
    endtask

    // Records cycles 1..n after the accepting edge while applying scripted start/reset
    task automatic capture(input int n, input int hs, input int he, input int pa, input int pb,
                           input int rst_at, input bit scramble);
        for (int j = 1; j <= n; j++) begin
            obs_vec[j]  = {busy, done, plot, xout, yout, colour};
            obs_addr[j] = rom_addr;
            start  = (j >= hs && j <= he) || j == pa || j == pb;
            resetn = (j != rst_at);
            if (scramble) begin
                x0 = 8'($urandom); y0 = 7'($urandom);
                sprite_sel = 1'($urandom); erase = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        start = 1'b0; resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; x0 = '0; y0 = '0; sprite_sel = 1'b0; erase = 1'b0;
        fill_rom_random();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_checks++; if (plot !== 1'b0) $display("FAIL reset_plot got %b want 0", plot); else n_pass++;
        n_checks++; if (xout !== 8'd0) $display("FAIL reset_xout got %0d want 0", xout); else n_pass++;
        n_checks++; if (yout !== 7'd0) $display("FAIL reset_yout got %0d want 0", yout); else n_pass++;
        n_checks++; if (colour !== 9'd0) $display("FAIL reset_colour got %h want 0", colour); else n_pass++;
        n_checks++; if (rom_addr !== 9'd0) $display("FAIL reset_rom_addr got %0d want 0", rom_addr); else n_pass++;
        resetn = 1'b1;
        m_x = '0; m_y = '0; m_c = '0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        int np, ep;
        fill_rom_random();
        kick(10, 20, 1, 0);
        capture(262, 0, -1, -1, -1, -1, 0);
        model_clear(); model_draw(0, 10, 20, 1, 0); model_finalize(262);
        np = 0; ep = 0;
        for (int j = 1; j <= 262; j++) begin
            np += int'(obs_vec[j][24]); ep += int'(e_plot[j]);
            n_checks++;
            if (obs_vec[j] !== exp_vec[j])
                $display("FAIL basic cycle %0d {busy,done,plot,x,y,col} got %h want %h", j, obs_vec[j], exp_vec[j]);
            else n_pass++;
            if (e_addr_en[j]) begin
                n_checks++;
                if (obs_addr[j] !== e_addr[j]) $display("FAIL basic_addr cycle %0d got %0d want %0d", j, obs_addr[j], e_addr[j]);
                else n_pass++;
            end
        end
        n_checks++; if (np !== ep) $display("FAIL basic_plot_count got %0d want %0d", np, ep); else n_pass++;
    endtask

    task automatic test_erase();
        int s, x, y;
        for (int i = 0; i < 512; i++) rom_mem[i] = 9'h0E0;
        s = $urandom_range(0, 1); x = $urandom_range(0, 255); y = $urandom_range(0, 127);
        kick(x, y, s, 1);
        capture(262, 0, -1, -1, -1, -1, 0);
        model_clear(); model_draw(0, x, y, s, 1); model_finalize(262);
        for (int j = 1; j <= 262; j++) begin
            n_checks++;
            if (obs_vec[j] !== exp_vec[j])
                $display("FAIL erase cycle %0d {busy,done,plot,x,y,col} got %h want %h", j, obs_vec[j], exp_vec[j]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        int s;
        fill_rom_random();
        s = $urandom_range(0, 1);
        kick(250, 120, s, 0);
        capture(262, 0, -1, -1, -1, -1, 0);
        model_clear(); model_draw(0, 250, 120, s, 0); model_finalize(262);
        for (int j = 1; j <= 262; j++) begin
            n_checks++;
            if (obs_vec[j] !== exp_vec[j])
                $display("FAIL wrap cycle %0d {busy,done,plot,x,y,col} got %h want %h", j, obs_vec[j], exp_vec[j]);
            else n_pass++;
        end
        n_checks++; if (obs_vec[17][23:16] !== 8'd9) $display("FAIL wrap_px15_x got %0d want 9", obs_vec[17][23:16]); else n_pass++;
        n_checks++; if (obs_vec[257][23:16] !== 8'd9) $display("FAIL wrap_px255_x got %0d want 9", obs_vec[257][23:16]); else n_pass++;
        n_checks++; if (obs_vec[257][15:9] !== 7'd7) $display("FAIL wrap_px255_y got %0d want 7", obs_vec[257][15:9]); else n_pass++;
    endtask

    task automatic test_ignore_start();
        int s, x, y, nd;
        bit e;
        fill_rom_random();
        s = $urandom_range(0, 1); x = $urandom_range(0, 255); y = $urandom_range(0, 127); e = 1'($urandom);
        kick(x, y, s, e);
        capture(262, 0, -1, 50, 100, -1, 1);
        model_clear(); model_draw(0, x, y, s, e); model_finalize(262);
        nd = 0;
        for (int j = 1; j <= 262; j++) begin
            nd += int'(obs_vec[j][25]);
            n_checks++;
            if (obs_vec[j] !== exp_vec[j])
                $display("FAIL ignore_start cycle %0d {busy,done,plot,x,y,col} got %h want %h", j, obs_vec[j], exp_vec[j]);
            else n_pass++;
        end
        n_checks++; if (nd !== 1) $display("FAIL ignore_start_done_count got %0d want 1", nd); else n_pass++;
        erase = 1'b0;
    endtask

    task automatic test_back_to_back();
        int s, x, y;
        fill_rom_random();
        s = $urandom_range(0, 1); x = $urandom_range(0, 255); y = $urandom_range(0, 127);
        kick(x, y, s, 0);
        capture(520, 1, 258, -1, -1, -1, 0);
        model_clear(); model_draw(0, x, y, s, 0); model_draw(258, x, y, s, 0); model_finalize(520);
        for (int j = 1; j <= 520; j++) begin
            n_checks++;
            if (obs_vec[j] !== exp_vec[j])
                $display("FAIL back_to_back cycle %0d {busy,done,plot,x,y,col} got %h want %h", j, obs_vec[j], exp_vec[j]);
            else n_pass++;
            if (e_addr_en[j]) begin
                n_checks++;
                if (obs_addr[j] !== e_addr[j]) $display("FAIL b2b_addr cycle %0d got %0d want %0d", j, obs_addr[j], e_addr[j]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int s, x, y, nd;
        fill_rom_random();
        s = $urandom_range(0, 1); x = $urandom_range(0, 255); y = $urandom_range(0, 127);
        kick(x, y, s, 0);
        capture(262, 0, -1, -1, -1, 100, 0);
        model_clear(); model_draw(0, x, y, s, 0); model_reset(100); model_finalize(262);
        nd = 0;
        for (int j = 1; j <= 262; j++) begin
            nd += int'(obs_vec[j][25]);
            n_checks++;
            if (obs_vec[j] !== exp_vec[j])
                $display("FAIL reset_mid cycle %0d {busy,done,plot,x,y,col} got %h want %h", j, obs_vec[j], exp_vec[j]);
            else n_pass++;
            if (e_addr_en[j]) begin
                n_checks++;
                if (obs_addr[j] !== e_addr[j]) $display("FAIL reset_mid_addr cycle %0d got %0d want %0d", j, obs_addr[j], e_addr[j]);
                else n_pass++;
            end
        end
        n_checks++; if (nd !== 0) $display("FAIL reset_mid_done_count got %0d want 0", nd); else n_pass++;
        s = $urandom_range(0, 1); x = $urandom_range(0, 255); y = $urandom_range(0, 127);
        kick(x, y, s, 0);
        capture(262, 0, -1, -1, -1, -1, 0);
        model_clear(); model_draw(0, x, y, s, 0); model_finalize(262);
        for (int j = 1; j <= 262; j++) begin
            n_checks++;
            if (obs_vec[j] !== exp_vec[j])
                $display("FAIL after_reset cycle %0d {busy,done,plot,x,y,col} got %h want %h", j, obs_vec[j], exp_vec[j]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            int s, x, y;
            bit e;
            fill_rom_random();
            s = $urandom_range(0, 1); x = $urandom_range(0, 255); y = $urandom_range(0, 127); e = 1'($urandom);
            kick(x, y, s, e);
            capture(262, 0, -1, -1, -1, -1, 0);
            model_clear(); model_draw(0, x, y, s, e); model_finalize(262);
            for (int j = 1; j <= 262; j++) begin
                n_checks++;
                if (obs_vec[j] !== exp_vec[j])
                    $display("FAIL random%0d cycle %0d {busy,done,plot,x,y,col} got %h want %h", r, j, obs_vec[j], exp_vec[j]);
                else n_pass++;
            end
        end
        erase = 1'b0;
    endtask

`ifdef SPRITE_TRANSPARENCY_EN
    task automatic test_transparency();
        int s, x, y, cnt, np;
        for (int i = 0; i < 512; i++) rom_mem[i] = 9'($urandom_range(1, 511));
        s = $urandom_range(0, 1); x = $urandom_range(0, 255); y = $urandom_range(0, 127);
        cnt = 0;
        while (cnt < 56) begin
            int p;
            p = $urandom_range(0, 255);
            if (rom_mem[s*N + p] != 9'h000) begin
                rom_mem[s*N + p] = 9'h000;
                cnt++;
            end
        end
        kick(x, y, s, 0);
        capture(262, 0, -1, -1, -1, -1, 0);
        model_clear(); model_draw(0, x, y, s, 0); model_finalize(262);
        np = 0;
        for (int j = 1; j <= 262; j++) begin
            np += int'(obs_vec[j][24]);
            n_checks++;
            if (obs_vec[j] !== exp_vec[j])
                $display("FAIL transparency cycle %0d {busy,done,plot,x,y,col} got %h want %h", j, obs_vec[j], exp_vec[j]);
            else n_pass++;
        end
        n_checks++; if (np !== 200) $display("FAIL transparency_plot_count got %0d want 200", np); else n_pass++;
        n_checks++; if (obs_vec[258][25] !== 1'b1) $display("FAIL transparency_done got %b want 1", obs_vec[258][25]); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_erase();
        test_wrap();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef SPRITE_TRANSPARENCY_EN
        test_transparency();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
